// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte stream and error pulses between uart_rx and its consumer
interface uart_rx_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_overrun;

  modport master (
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_overrun,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_overrun,
    output i_ready
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ready byte output; UART_RX_MAJORITY_EN enables 2-of-3 bit voting
module uart_rx #(
  parameter int clk_freq_hz = 30000000,
  parameter int baud_rate   = 115200
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_uart_rx,
  uart_rx_if.master rx_if
);

  localparam int BIT_CNT = clk_freq_hz / baud_rate;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT) + 1;

  // The voting window ends one cycle after counter==0, so every load is one
  // shorter to keep the decision cycle (and o_valid timing) where it was.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] START_LD = CW'(HALF - 2);
  localparam logic [CW-1:0] RELOAD   = CW'(BIT_CNT - 2);
`else
  localparam logic [CW-1:0] START_LD = CW'(HALF - 1);
  localparam logic [CW-1:0] RELOAD   = CW'(BIT_CNT - 1);
`endif

  if (BIT_CNT < 4) begin : g_bit_cnt_check
    $error("uart_rx: clk_freq_hz/baud_rate must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic          sync1, rx_s;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    data_n;
  logic          valid_n, fe_n, ov_n;
  logic          sample_evt, bit_val, complete, accept;

`ifdef UART_RX_MAJORITY_EN
  logic s_a, s_a_n, s_b, s_b_n, pend, pend_n;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1             <= 1'b1;
      rx_s              <= 1'b1;
      state             <= S_IDLE;
      cnt               <= '0;
      idx               <= '0;
      shreg             <= '0;
      rx_if.o_data      <= '0;
      rx_if.o_valid     <= 1'b0;
      rx_if.o_frame_err <= 1'b0;
      rx_if.o_overrun   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      s_a               <= 1'b1;
      s_b               <= 1'b1;
      pend              <= 1'b0;
`endif
    end else begin
      sync1             <= i_uart_rx;
      rx_s              <= sync1;
      state             <= state_n;
      cnt               <= cnt_n;
      idx               <= idx_n;
      shreg             <= shreg_n;
      rx_if.o_data      <= data_n;
      rx_if.o_valid     <= valid_n;
      rx_if.o_frame_err <= fe_n;
      rx_if.o_overrun   <= ov_n;
`ifdef UART_RX_MAJORITY_EN
      s_a               <= s_a_n;
      s_b               <= s_b_n;
      pend              <= pend_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shreg_n  = shreg;
    data_n   = rx_if.o_data;
    valid_n  = rx_if.o_valid;
    fe_n     = 1'b0;
    ov_n     = 1'b0;
    complete = 1'b0;
    accept   = rx_if.o_valid & rx_if.i_ready;
`ifdef UART_RX_MAJORITY_EN
    s_a_n      = s_a;
    s_b_n      = s_b;
    pend_n     = 1'b0;
    sample_evt = pend;
    bit_val    = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
`else
    sample_evt = (cnt == '0);
    bit_val    = rx_s;
`endif

    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_n = S_START;
          cnt_n   = START_LD;
        end
      end
      S_START, S_DATA, S_STOP: begin
`ifdef UART_RX_MAJORITY_EN
        if (!pend && cnt == CW'(1)) s_a_n = rx_s;
        if (!pend && cnt == '0) begin
          s_b_n  = rx_s;
          pend_n = 1'b1;
        end
`endif
        // Counter parks at zero until the sample decision reloads it.
        if (cnt != '0) cnt_n = cnt - CW'(1);
        if (sample_evt) begin
          if (state == S_START) begin
            if (bit_val) begin
              state_n = S_IDLE;
            end else begin
              state_n = S_DATA;
              cnt_n   = RELOAD;
              idx_n   = '0;
            end
          end else if (state == S_DATA) begin
            shreg_n[idx] = bit_val;
            cnt_n        = RELOAD;
            if (idx == 3'd7) state_n = S_STOP;
            else             idx_n   = idx + 3'd1;
          end else begin
            if (bit_val) begin
              complete = 1'b1;
              state_n  = S_IDLE;
            end else begin
              fe_n    = 1'b1;
              state_n = S_BREAK;
            end
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // A held byte wins over a new one unless it is being accepted right now.
    if (complete) begin
      if (!rx_if.o_valid || accept) begin
        data_n  = shreg;
        valid_n = 1'b1;
      end else begin
        ov_n = 1'b1;
      end
    end else if (accept) begin
      valid_n = 1'b0;
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side partner of the SoC UART transmitter: samples the asynchronous serial line and recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop).
- Presents each received byte on a valid/ready stream toward the bus peripheral wrapper or CPU-side FIFO.
- Flags framing errors and overruns as single-cycle pulses.
- Timing is derived from the same clk_freq_hz/baud_rate parameters as the transmitter, so both ends of a link built from these blocks agree on bit time.

Parameters:
- clk_freq_hz, 30000000: i_clk frequency in Hz.
- baud_rate, 115200: line bit rate.
- Derived: BIT_CNT = clk_freq_hz/baud_rate (integer divide), HALF = BIT_CNT/2. BIT_CNT >= 4 is required; an elaboration-time check fails otherwise.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset, synchronous, active-high.
- i_uart_rx  input  1  asynchronous serial line, idle high.
- o_data  output  8  received byte, stable while o_valid=1.
- o_valid  output  1  byte available.
- i_ready  input  1  consumer accepts byte when o_valid & i_ready.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- o_overrun  output  1  one-cycle pulse: byte completed while the previous byte is still unaccepted.

Behaviour:
- Synchronizer: 2-flop chain on i_uart_rx, both flops reset to 1. All decisions use the synchronized value rx_s.
- Reset values: o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, state=IDLE, counter=0, bit index=0.
- Reset applies mid-frame: any partial byte is discarded and the FSM returns to IDLE.
- IDLE: when rx_s=0, load counter=HALF-1 and go to START.
- START: decrement counter each cycle. At counter==0, sample the line.
  - Sample 0: load counter=BIT_CNT-1, bit index=0, go to DATA.
  - Sample 1: treat as a glitch, return to IDLE with no output.
- DATA: at counter==0, shift the sample into bit[index] (LSB first) and reload counter=BIT_CNT-1. After index 7, go to STOP.
- STOP: at counter==0, sample the line.
  - Sample 1: byte completes; go to IDLE.
  - Sample 0: pulse o_frame_err the next cycle, drop the byte, go to BREAK.
- BREAK: wait until rx_s=1, then go to IDLE. A held-low line produces exactly one o_frame_err.
- Latency: o_valid rises one cycle after the stop-bit sample cycle. The line falling edge to o_valid is 2 + HALF + 9*BIT_CNT + 1 cycles, ±1 cycle for synchronizer phase.
- Output handshake:
  - o_valid stays high until o_valid & i_ready. On the cycle after acceptance, o_valid=0 unless a new byte completes on the acceptance cycle.
  - Completion while o_valid=1 and i_ready=0: the held byte is kept, the new byte is dropped, and o_overrun pulses for 1 cycle.
  - Completion on the same cycle as acceptance: the new byte loads into o_data, o_valid stays 1, no overrun.
- The receiver never stalls the line. Reception continues regardless of i_ready.
- Counter width is $clog2(BIT_CNT)+1 bits. The counter must not underflow or wrap in any state. In IDLE and BREAK it holds.
- o_frame_err and o_overrun never assert on the same cycle, because a frame-error frame never completes as a byte.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined:
  - Each sample point (start, data, stop) takes rx_s on three consecutive cycles: counter==1, 0, and the cycle after 0.
  - The bit value is the 2-of-3 majority. The reload after the sample point is adjusted by -1 so the bit period stays BIT_CNT.
  - A start glitch shorter than 2 cycles at the sample point is rejected.
- Not defined: a single sample at counter==0, as described above.
- Latency is identical in both builds. o_valid timing must not change.

Test Plan (clk_freq_hz=1000000, baud_rate=100000, so BIT_CNT=10, HALF=5):
- Single frame 0xA5, i_ready=1 -> o_valid one cycle with o_data=0xA5, 2+5+90+1 cycles after the falling edge (±1), no error pulses.
- Back-to-back 0x00 then 0xFF with no idle gap, i_ready held 0 until the second completes -> o_data=0x00 retained, o_overrun one pulse; after an i_ready pulse, o_valid=0.
- Completion coincident with i_ready=1 on a pending byte 0x11, new byte 0x22 -> o_valid stays 1, o_data=0x22, o_overrun=0.
- Stop bit driven 0, then line held low for 50 cycles, then high, then frame 0x3C -> exactly one o_frame_err, no o_valid for the bad frame, then 0x3C received correctly.
- Start glitch: line low 3 cycles, then high -> FSM returns to IDLE, no output. Then i_rst asserted mid-frame at data bit 4 -> all outputs 0, next full frame 0x5A received correctly.
- With UART_RX_MAJORITY_EN: 1-cycle low glitch at the mid-point of data bit 3 in frame 0xFF -> o_data=0xFF. Without the macro, the same glitch exactly at counter==0 -> o_data=0xF7.
